// File: rtl/lfsr_period_display.sv
// Measures the repeat period of the lfsr4 output for the current mode, samples it
// periodically, and drives a 7-segment display with either the sample or the period.
module lfsr_period_display #(
   parameter int PRESCALE   = 1,
   parameter int MAX_PERIOD = 31,
   localparam int PW        = $clog2(MAX_PERIOD + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [3:0]    lfsr,
   input  logic [2:0]    mod,
   input  logic          restart,
   input  logic          show_period,
   output logic [6:0]    seg,
   output logic          dp,
   output logic [PW-1:0] period,
   output logic          period_valid,
   output logic          timeout
);

   localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ARM     = 3'd1;
   localparam logic [2:0] ST_MEASURE = 3'd2;
   localparam logic [2:0] ST_DONE    = 3'd3;
   localparam logic [2:0] ST_TIMEOUT = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [3:0]    ref_q, ref_d;
   logic [PW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] period_q, period_d;
   logic [3:0]    sample_q, sample_d;
   logic [PSW-1:0] presc_q, presc_d;
   logic [2:0]    mod_q;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic          mod_chg;
   logic [7:0]    period_ext;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   assign mod_chg    = (mod != mod_q);
   assign period_ext = 8'(period_q);

   // Restart or a mode change aborts whatever is in progress and re-measures.
   always_comb begin
      state_d  = state_q;
      ref_d    = ref_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      if (restart || mod_chg) begin
         state_d  = ST_IDLE;
         period_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d  = ST_ARM;
               period_d = '0;
            end
            ST_ARM: begin
               ref_d   = lfsr;
               cnt_d   = PW'(1);
               state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
               if (lfsr == ref_q) begin
                  period_d = cnt_q;
                  state_d  = ST_DONE;
               end else if (cnt_q == PW'(MAX_PERIOD)) begin
                  period_d = '0;
                  state_d  = ST_TIMEOUT;
               end else begin
                  cnt_d = cnt_q + PW'(1);
               end
            end
            ST_DONE, ST_TIMEOUT: state_d = state_q;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      presc_d  = presc_q;
      sample_d = sample_q;
      if (presc_q == PSW'(PRESCALE - 1)) begin
         presc_d  = '0;
         sample_d = lfsr;
      end else begin
         presc_d = presc_q + PSW'(1);
      end
   end

   // dp doubles as the "period >= 16" flag in DONE and the busy flag while measuring.
   always_comb begin
      seg_d = hex7(sample_q);
      dp_d  = 1'b0;
      if (show_period) begin
         case (state_q)
            ST_DONE: begin
               seg_d = hex7(period_ext[3:0]);
               dp_d  = |period_ext[7:4];
            end
            ST_TIMEOUT: begin
               seg_d = 7'h40;
               dp_d  = 1'b0;
            end
            default: begin
               seg_d = 7'h00;
               dp_d  = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         ref_q    <= '0;
         cnt_q    <= '0;
         period_q <= '0;
         sample_q <= '0;
         presc_q  <= '0;
         mod_q    <= '0;
         seg_q    <= '0;
         dp_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         ref_q    <= ref_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         sample_q <= sample_d;
         presc_q  <= presc_d;
         mod_q    <= mod;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
      end
   end

   assign seg          = seg_q;
   assign dp           = dp_q;
   assign period       = period_q;
   assign period_valid = (state_q == ST_DONE);
   assign timeout      = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_lfsr_period_display.sv
// Scoreboard bench for lfsr_period_display: default, short-timeout and prescaled
// instances share stimulus and are enabled one at a time through their resets.
module tb_lfsr_period_display;

   localparam int PAT_HOLD = 0;
   localparam int PAT_SEQ  = 1;
   localparam int PAT_RAMP = 2;

   typedef struct packed {
      logic [7:0] period;
      logic       to;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_m = 1'b1, reset_t = 1'b1, reset_p = 1'b1;
   logic [3:0] lfsr = 4'h0;
   logic [2:0] mod = 3'd0;
   logic       restart = 1'b0;
   logic       show_period = 1'b1;

   logic [6:0] m_seg, t_seg, p_seg;
   logic       m_dp, t_dp, p_dp;
   logic [4:0] m_period, p_period;
   logic [3:0] t_period;
   logic       m_valid, t_valid, p_valid;
   logic       m_timeout, t_timeout, p_timeout;

   int tests_run = 0;
   int tests_failed = 0;

   exp_t exp_main[$];
   exp_t exp_to[$];

   int         pat = PAT_HOLD;
   int         idx = 0;
   logic [3:0] hold_val = 4'h0;
   logic [3:0] seq15 [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                              4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
   logic [6:0] ps_seg_exp [5] = '{7'h3F, 7'h4F, 7'h07, 7'h7C, 7'h71};

   lfsr_period_display dut_m (
      .clk(clk), .reset(reset_m), .lfsr(lfsr), .mod(mod), .restart(restart),
      .show_period(show_period), .seg(m_seg), .dp(m_dp), .period(m_period),
      .period_valid(m_valid), .timeout(m_timeout));

   lfsr_period_display #(.MAX_PERIOD(8)) dut_t (
      .clk(clk), .reset(reset_t), .lfsr(lfsr), .mod(mod), .restart(restart),
      .show_period(show_period), .seg(t_seg), .dp(t_dp), .period(t_period),
      .period_valid(t_valid), .timeout(t_timeout));

   lfsr_period_display #(.PRESCALE(4)) dut_p (
      .clk(clk), .reset(reset_p), .lfsr(lfsr), .mod(mod), .restart(restart),
      .show_period(show_period), .seg(p_seg), .dp(p_dp), .period(p_period),
      .period_valid(p_valid), .timeout(p_timeout));

   always #5 clk = ~clk;

   function automatic logic [3:0] pat_val(input int p, input int i);
      logic [3:0] v;
      v = hold_val;
      if (p == PAT_SEQ) v = seq15[i % 15];
      else if (p == PAT_RAMP) v = 4'(i);
      return v;
   endfunction

   // Stimulus generator: lfsr advances just after each rising edge.
   initial forever begin
      @(posedge clk);
      #1;
      idx = idx + 1;
      lfsr = pat_val(pat, idx);
   end

   task automatic applyStimulus(input int p, input logic [3:0] hv);
      pat = p;
      hold_val = hv;
      idx = 0;
      lfsr = pat_val(p, 0);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests_run++;
      if (act !== expv) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic pushMain(input logic [7:0] p, input logic to, input logic [6:0] s, input logic d);
      exp_t e;
      e.period = p; e.to = to; e.seg = s; e.dp = d;
      exp_main.push_back(e);
   endtask

   task automatic waitDrain(input int which, input int bound);
      int n = 0;
      while (((which == 0) ? exp_main.size() : exp_to.size()) != 0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (((which == 0) ? exp_main.size() : exp_to.size()) != 0) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL drain_%0d: got no result after %0d cycles expected a result", which, bound);
         if (which == 0) exp_main.delete(); else exp_to.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   logic m_prev = 1'b0;
   initial forever begin
      exp_t e;
      @(negedge clk);
      if ((m_valid || m_timeout) && !m_prev) begin
         if (exp_main.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL main_unexpected: got period %0d expected no result", m_period);
         end else begin
            e = exp_main.pop_front();
            checkOutput("main_period", 32'(m_period), 32'(e.period));
            checkOutput("main_timeout", 32'(m_timeout), 32'(e.to));
            @(negedge clk);
            checkOutput("main_seg", 32'(m_seg), 32'(e.seg));
            checkOutput("main_dp", 32'(m_dp), 32'(e.dp));
         end
      end
      m_prev = m_valid || m_timeout;
   end

   logic t_prev = 1'b0;
   initial forever begin
      exp_t e;
      @(negedge clk);
      if ((t_valid || t_timeout) && !t_prev) begin
         if (exp_to.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL to_unexpected: got period %0d expected no result", t_period);
         end else begin
            e = exp_to.pop_front();
            checkOutput("to_period", 32'(t_period), 32'(e.period));
            checkOutput("to_timeout", 32'(t_timeout), 32'(e.to));
            @(negedge clk);
            checkOutput("to_seg", 32'(t_seg), 32'(e.seg));
            checkOutput("to_dp", 32'(t_dp), 32'(e.dp));
         end
      end
      t_prev = t_valid || t_timeout;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      exp_t e;
      repeat (3) @(negedge clk);
      checkOutput("rst_period", 32'(m_period), 0);
      checkOutput("rst_valid", 32'(m_valid), 0);
      checkOutput("rst_timeout", 32'(m_timeout), 0);
      checkOutput("rst_seg", 32'(m_seg), 0);
      checkOutput("rst_dp", 32'(m_dp), 0);
      checkOutput("rst_to_seg", 32'(t_seg), 0);

      // Maximal 15-state sequence.
      applyStimulus(PAT_SEQ, 4'h0);
      pushMain(8'd15, 1'b0, 7'h71, 1'b0);
      reset_m = 1'b0;
      repeat (18) @(negedge clk);
      checkOutput("seq_valid_by_18", 32'(m_valid), 1);
      waitDrain(0, 30);

      // Stuck value: period 1 on the third clock.
      reset_m = 1'b1;
      @(negedge clk);
      applyStimulus(PAT_HOLD, 4'h0);
      pushMain(8'd1, 1'b0, 7'h06, 1'b0);
      reset_m = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("stuck_valid_clk2", 32'(m_valid), 0);
      @(negedge clk);
      checkOutput("stuck_valid_clk3", 32'(m_valid), 1);
      checkOutput("stuck_period_clk3", 32'(m_period), 1);
      waitDrain(0, 10);

      // Ramp: period 16 shows 0 with dp set.
      reset_m = 1'b1;
      @(negedge clk);
      applyStimulus(PAT_RAMP, 4'h0);
      pushMain(8'd16, 1'b0, 7'h3F, 1'b1);
      reset_m = 1'b0;
      waitDrain(0, 40);
      reset_m = 1'b1;

      // Timeout instance with MAX_PERIOD=8.
      @(negedge clk);
      applyStimulus(PAT_SEQ, 4'h0);
      e.period = 8'd0; e.to = 1'b1; e.seg = 7'h40; e.dp = 1'b0;
      exp_to.push_back(e);
      reset_t = 1'b0;
      waitDrain(1, 30);
      reset_t = 1'b1;

      // Mode change mid-measure, then in DONE.
      @(negedge clk);
      applyStimulus(PAT_SEQ, 4'h0);
      reset_m = 1'b0;
      repeat (5) @(negedge clk);
      mod = 3'd1;
      @(negedge clk);
      checkOutput("modm_period", 32'(m_period), 0);
      checkOutput("modm_dp", 32'(m_dp), 1);
      repeat (12) @(negedge clk);
      checkOutput("modm_remeasuring", 32'(m_valid), 0);
      pushMain(8'd15, 1'b0, 7'h71, 1'b0);
      waitDrain(0, 20);
      mod = 3'd2;
      @(negedge clk);
      checkOutput("modd_period", 32'(m_period), 0);
      checkOutput("modd_valid", 32'(m_valid), 0);
      @(negedge clk);
      checkOutput("modd_seg", 32'(m_seg), 0);
      checkOutput("modd_dp", 32'(m_dp), 1);
      pushMain(8'd15, 1'b0, 7'h71, 1'b0);
      waitDrain(0, 25);

      // Same again with restart pulses: DONE first, then mid-measure.
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      checkOutput("rstd_period", 32'(m_period), 0);
      checkOutput("rstd_valid", 32'(m_valid), 0);
      @(negedge clk);
      checkOutput("rstd_seg", 32'(m_seg), 0);
      checkOutput("rstd_dp", 32'(m_dp), 1);
      repeat (3) @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      checkOutput("rstm_valid", 32'(m_valid), 0);
      repeat (12) @(negedge clk);
      checkOutput("rstm_remeasuring", 32'(m_valid), 0);
      pushMain(8'd15, 1'b0, 7'h71, 1'b0);
      waitDrain(0, 20);
      reset_m = 1'b1;
      mod = 3'd0;

      // Prescaled sampler on a ramp, then reset mid-run.
      @(negedge clk);
      show_period = 1'b0;
      applyStimulus(PAT_RAMP, 4'h0);
      reset_p = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         checkOutput($sformatf("ps_seg_%0d", n), 32'(p_seg), 32'(ps_seg_exp[(n - 1) / 4]));
      end
      checkOutput("ps_dp", 32'(p_dp), 0);
      checkOutput("ps_valid", 32'(p_valid), 1);
      checkOutput("ps_period", 32'(p_period), 16);
      reset_p = 1'b1;
      #1;
      checkOutput("ps_rst_seg", 32'(p_seg), 0);
      checkOutput("ps_rst_dp", 32'(p_dp), 0);
      checkOutput("ps_rst_valid", 32'(p_valid), 0);
      checkOutput("ps_rst_period", 32'(p_period), 0);

      repeat (2) @(negedge clk);
      checkOutput("leftover_main", exp_main.size(), 0);
      checkOutput("leftover_to", exp_to.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
